// File: rtl/vedic_pkg.sv
// Types and default widths shared by the divider and the 2x2 multiplier datapath.
package vedic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Divider defaults invert the multiplier: 4-bit product, 2-bit operands.
   localparam int DW_DEF = 4;
   localparam int VW_DEF = 2;

endpackage

// File: rtl/vedic_divider_div_step.sv
// One combinational restoring-division step built on a ripple full_add chain,
// the same adder cell the multiplier uses.
module full_add (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module div_step #(
   parameter int VW = 2
) (
   input  logic [VW-1:0] pr_in,
   input  logic          bit_in,
   input  logic [VW-1:0] divisor,
   output logic [VW-1:0] pr_out,
   output logic          q_bit
);
   logic [VW:0]   shifted;
   logic [VW:0]   sub_b;
   logic [VW:0]   diff;
   logic [VW+1:0] carry;

   assign shifted  = {pr_in, bit_in};
   assign sub_b    = ~{1'b0, divisor};
   assign carry[0] = 1'b1;

   for (genvar i = 0; i <= VW; i++) begin : g_fa
      full_add u_fa (
         .a    (shifted[i]),
         .b    (sub_b[i]),
         .cin  (carry[i]),
         .s    (diff[i]),
         .cout (carry[i+1])
      );
   end

   // No borrow means shifted >= divisor; the difference is then below divisor, so its MSB is clear.
   assign q_bit  = carry[VW+1] & ~diff[VW];
   assign pr_out = q_bit ? diff[VW-1:0] : shifted[VW-1:0];

endmodule

// File: rtl/vedic_divider.sv
// Sequential restoring divider, one quotient bit per clock, valid/ready on both sides.
//   state   | meaning
//   ST_IDLE | in_ready high, waiting for an operand pair
//   ST_RUN  | one restoring step per clock, MSB first, DW steps
//   ST_DONE | result held; out_valid high until out_ready
module vedic_divider
   import vedic_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int VW = VW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_zero
);
   localparam int CW = (DW > 1) ? $clog2(DW) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

   state_t        state_q, state_d;
   logic [DW-1:0] quot_q,  quot_d;
   logic [VW-1:0] pr_q,    pr_d;
   logic [VW-1:0] dvs_q,   dvs_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic          dz_q,    dz_d;
   logic          hold_q,  hold_d;

   logic [VW-1:0] step_pr;
   logic          step_bit;

   div_step #(.VW(VW)) u_step (
      .pr_in   (pr_q),
      .bit_in  (quot_q[DW-1]),
      .divisor (dvs_q),
      .pr_out  (step_pr),
      .q_bit   (step_bit)
   );

   assign in_ready  = (state_q == ST_IDLE);
   // A zero-divisor result waits one cycle in DONE so it appears one cycle after accept.
   assign out_valid = (state_q == ST_DONE) && !hold_q;
   assign quotient  = quot_q;
   assign remainder = pr_q;
   assign div_zero  = dz_q;

   always_comb begin
      state_d = state_q;
      quot_d  = quot_q;
      pr_d    = pr_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      dz_d    = dz_q;
      hold_d  = hold_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               dvs_d = divisor;
               cnt_d = '0;
               pr_d  = '0;
               if (divisor == '0) begin
                  quot_d  = '1;
                  dz_d    = 1'b1;
                  hold_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  quot_d  = dividend;
                  dz_d    = 1'b0;
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            pr_d   = step_pr;
            quot_d = {quot_q[DW-2:0], step_bit};
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            hold_d = 1'b0;
            if (out_valid && out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         quot_q  <= '0;
         pr_q    <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         dz_q    <= 1'b0;
         hold_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         quot_q  <= quot_d;
         pr_q    <= pr_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         dz_q    <= dz_d;
         hold_q  <= hold_d;
      end
   end

endmodule

// File: tb/tb_vedic_divider.sv
// Scoreboard bench for vedic_divider: accepts push a reference result, a monitor pops on output.
module tb_vedic_divider;
   localparam int DW = 4;
   localparam int VW = 2;

   typedef struct {
      logic [DW-1:0] q;
      logic [VW-1:0] r;
      logic          dz;
      int            dvd;
      int            dvs;
      int            acc;
      int            lat;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          div_zero;

   exp_t sb[$];
   int   nvec = 0;
   int   nerr = 0;
   int   cyc = 0;
   int   rdy_mode = 0;

   vedic_divider #(.DW(DW), .VW(VW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always begin
      @(posedge clk);
      #2;
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b0;
      endcase
   end

   task automatic chk(string name, int act, int req);
      nvec++;
      if (act != req) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic exp_t model(int a, int b, int now);
      exp_t e;
      e.dvd = a;
      e.dvs = b;
      e.acc = now + 1;
      if (b == 0) begin
         e.q   = DW'((1 << DW) - 1);
         e.r   = '0;
         e.dz  = 1'b1;
         e.lat = 1;
      end else begin
         e.q   = DW'(a / b);
         e.r   = VW'(a % b);
         e.dz  = 1'b0;
         e.lat = DW;
      end
      return e;
   endfunction

   // Output monitor and accept tracker, sampled on the falling edge.
   bit seen_valid = 0;
   bit hs_prev = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         seen_valid = 0;
         hs_prev    = 0;
      end else begin
         if (hs_prev) chk("ready_after_hs", int'(in_ready), 1);
         hs_prev = 0;
         if (out_valid) begin
            chk("ready_low_in_done", int'(in_ready), 0);
            if (sb.size() == 0) begin
               chk("unexpected_out_valid", 1, 0);
            end else begin
               exp_t e;
               e = sb[0];
               if (!seen_valid) begin
                  seen_valid = 1;
                  chk("latency", cyc - e.acc, e.lat);
               end
               chk("quotient", int'(quotient), int'(e.q));
               chk("remainder", int'(remainder), int'(e.r));
               chk("div_zero", int'(div_zero), int'(e.dz));
               if (e.dvs != 0) begin
                  chk("identity", int'(quotient) * e.dvs + int'(remainder), e.dvd);
                  chk("rem_lt_div", int'(int'(remainder) < e.dvs), 1);
               end
               if (out_ready) begin
                  void'(sb.pop_front());
                  seen_valid = 0;
                  hs_prev    = 1;
               end
            end
         end
         if (in_valid && in_ready) begin
            sb.push_back(model(int'(dividend), int'(divisor), cyc));
         end
      end
   end

   task automatic do_op(int a, int b);
      int n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!in_ready) begin
         chk("in_ready_timeout", 0, 1);
         return;
      end
      in_valid = 1'b1;
      dividend = DW'(a);
      divisor  = VW'(b);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      @(posedge clk);
      #1;
      chk("drain_pending", sb.size(), 0);
   endtask

   task automatic chk_reset_vals(string tag);
      chk({tag, "_quotient"}, int'(quotient), 0);
      chk({tag, "_remainder"}, int'(remainder), 0);
      chk({tag, "_div_zero"}, int'(div_zero), 0);
      chk({tag, "_out_valid"}, int'(out_valid), 0);
      chk({tag, "_in_ready"}, int'(in_ready), 1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      rst_n = 1'b1;

      do_op(9, 2);
      do_op(15, 3);
      do_op(0, 1);
      do_op(5, 0);
      drain();

      // Backpressure: result held, in_ready low, stray in_valid ignored.
      rdy_mode = 2;
      do_op(9, 2);
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("bp_valid_seen", int'(out_valid), 1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         in_valid = (i % 2 == 0);
         dividend = 4'd7;
         divisor  = 2'd1;
      end
      in_valid = 1'b0;
      rdy_mode = 0;
      drain();

      // Reset during the second RUN cycle.
      do_op(13, 3);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk_reset_vals("abort");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (DW + 3) begin
         @(posedge clk);
         #1;
         chk("no_valid_after_abort", int'(out_valid), 0);
      end
      do_op(6, 2);
      drain();

      // Every operand pair, then random pairs, under random backpressure.
      rdy_mode = 1;
      for (int a = 0; a < (1 << DW); a++) begin
         for (int b = 0; b < (1 << VW); b++) begin
            do_op(a, b);
         end
      end
      for (int k = 0; k < 40; k++) begin
         do_op(int'($urandom_range(0, (1 << DW) - 1)), int'($urandom_range(0, (1 << VW) - 1)));
      end
      rdy_mode = 0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
